// File: rtl/seq_detector_param_if.sv
// Serial-detector bus: bit stream, mode and pattern-load controls in; match and debug status out.
interface seq_detector_param_if #(
    parameter int unsigned PAT_LEN = 5,
    parameter int unsigned CNT_W   = 8
);
    localparam int unsigned SW = $clog2(PAT_LEN);

    logic               en;
    logic               din;
    logic               overlap;
    logic               pat_load;
    logic [PAT_LEN-1:0] pat_in;
    logic               match;
    logic [SW-1:0]      state_o;
    logic [CNT_W-1:0]   match_cnt;
    logic               cnt_sat;

    modport master (
        output en, din, overlap, pat_load, pat_in,
        input  match, state_o, match_cnt, cnt_sat
    );

    modport slave (
        input  en, din, overlap, pat_load, pat_in,
        output match, state_o, match_cnt, cnt_sat
    );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial-pattern detector with run-time pattern reload and overlap control.
// Optional saturating match counter enabled by defining MATCH_CNT_EN.
module seq_detector_param #(
    parameter int unsigned        PAT_LEN  = 5,
    parameter logic [PAT_LEN-1:0] PAT_INIT = 5'b10010,
    parameter int unsigned        CNT_W    = 8
) (
    input logic                 clk,
    input logic                 rst,
    seq_detector_param_if.slave bus
);
    localparam int unsigned SW = $clog2(PAT_LEN);

    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [SW-1:0]      state_q, state_d;
    logic [PAT_LEN-1:0] win;
    logic [SW-1:0]      nxt;
    logic               found;
    logic               eq;
    logic               match;

    // Newest bit at LSB; bit PAT_LEN-1 of the pattern is the first-received bit.
    assign win   = {hist_q, bus.din};
    assign match = bus.en & ~bus.pat_load & (state_q == SW'(PAT_LEN - 1)) & (bus.din == pat_q[0]);

    // Longest prefix that is a suffix of the window; capping at state+1 keeps
    // stale/cleared history from producing false prefixes. On a full match this
    // naturally yields the pattern's longest proper border.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        eq    = 1'b0;
        for (int j = PAT_LEN - 1; j >= 1; j--) begin
            eq = 1'b1;
            for (int i = 0; i < j; i++) begin
                if (pat_q[PAT_LEN-1-i] != win[j-1-i]) eq = 1'b0;
            end
            if (!found && eq && (j <= int'(state_q) + 1)) begin
                nxt   = SW'(j);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        pat_d   = pat_q;
        hist_d  = hist_q;
        state_d = state_q;
        if (bus.pat_load) begin
            pat_d   = bus.pat_in;
            hist_d  = '0;
            state_d = '0;
        end else if (bus.en) begin
            if (match && !bus.overlap) begin
                hist_d  = '0;
                state_d = '0;
            end else begin
                hist_d  = win[PAT_LEN-2:0];
                state_d = nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q   <= PAT_INIT;
            hist_q  <= '0;
            state_q <= '0;
        end else begin
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            state_q <= state_d;
        end
    end

    assign bus.match   = match;
    assign bus.state_o = state_q;

`ifdef MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    always_comb begin
        cnt_d = cnt_q;
        if (bus.pat_load) begin
            cnt_d = '0;
        end else if (match && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
        sat_d = &cnt_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign bus.match_cnt = cnt_q;
    assign bus.cnt_sat   = sat_q;
`else
    assign bus.match_cnt = {CNT_W{1'b0}};
    assign bus.cnt_sat   = 1'b0;
`endif
endmodule
